// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch flush, dmem waits.
// Optional HAZARD_STATS_EN adds saturating stall/flush statistics counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_ADDR_W   = 5,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MAX_MEM_WAIT = 15
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  branch_taken,
   input  logic                  dmem_busy,
   output logic                  pc_write_en,
   output logic                  if_id_write_en,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  ex_mem_hold,
`ifdef HAZARD_STATS_EN
   output logic [15:0]           stall_cnt,
   output logic [15:0]           flush_cnt_total,
`endif
   output logic                  timeout_err
);

   typedef enum logic [1:0] {StRun, StFlush, StMemWait, StHalt} state_e;

   // Output vectors: {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold}
   localparam logic [4:0] OutNormal = 5'b11000;
   localparam logic [4:0] OutStall  = 5'b00010;
   localparam logic [4:0] OutFlush  = 5'b11110;
   localparam logic [4:0] OutWait   = 5'b00001;
   localparam logic [4:0] OutHalt   = 5'b00011;
   localparam logic [4:0] OutReset  = 5'b00110;

   localparam logic [2:0] FlushInit   = 3'(FLUSH_CYCLES);
   localparam logic [2:0] FlushReload = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] MaxWait     = 8'(MAX_MEM_WAIT);

   state_e     state_q, state_d;
   logic [2:0] flush_cnt_q, flush_cnt_d;
   logic [2:0] flush_pend_q, flush_pend_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       timeout_q, timeout_d;
   logic       load_use;
   logic [7:0] wait_inc;
   logic [4:0] outs;

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

   assign wait_inc = (wait_cnt_q < MaxWait) ? wait_cnt_q + 8'd1 : wait_cnt_q;

   always_comb begin
      outs = OutNormal;
      if (!resetn) begin
         outs = OutReset;
      end else begin
         unique case (state_q)
            StRun: begin
               if (dmem_busy)         outs = OutWait;
               else if (branch_taken) outs = OutFlush;
               else if (load_use)     outs = OutStall;
               else                   outs = OutNormal;
            end
            StFlush:   outs = dmem_busy ? OutWait : OutFlush;
            StMemWait: outs = OutWait;
            default:   outs = OutHalt;
         endcase
      end
   end

   assign {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold} = outs;
   assign timeout_err = timeout_q;

   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      flush_pend_d = flush_pend_q;
      wait_cnt_d   = wait_cnt_q;
      timeout_d    = timeout_q;
      unique case (state_q)
         StRun, StFlush: begin
            if (dmem_busy) begin
               // The flush slot is lost to the stall; resume it after the wait.
               wait_cnt_d   = 8'd1;
               flush_cnt_d  = '0;
               state_d      = StMemWait;
               if (branch_taken)          flush_pend_d = FlushInit;
               else if (state_q == StRun) flush_pend_d = '0;
               else                       flush_pend_d = flush_cnt_q;
               if (8'd1 >= MaxWait) begin
                  timeout_d = 1'b1;
                  state_d   = StHalt;
               end
            end else if (branch_taken) begin
               flush_cnt_d = FlushReload;
               state_d     = (FlushReload != '0) ? StFlush : StRun;
            end else if (state_q == StFlush) begin
               if (flush_cnt_q <= 3'd1) begin
                  flush_cnt_d = '0;
                  state_d     = StRun;
               end else begin
                  flush_cnt_d = flush_cnt_q - 3'd1;
               end
            end
         end
         StMemWait: begin
            if (dmem_busy) begin
               wait_cnt_d = wait_inc;
               if (branch_taken) flush_pend_d = FlushInit;
               if (wait_inc >= MaxWait) begin
                  timeout_d = 1'b1;
                  state_d   = StHalt;
               end
            end else begin
               wait_cnt_d = '0;
               if (flush_pend_q != '0) begin
                  flush_cnt_d  = flush_pend_q;
                  flush_pend_d = '0;
                  state_d      = StFlush;
               end else begin
                  state_d = StRun;
               end
            end
         end
         default: state_d = StHalt;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StRun;
         flush_cnt_q  <= '0;
         flush_pend_q <= '0;
         wait_cnt_q   <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         flush_pend_q <= flush_pend_d;
         wait_cnt_q   <= wait_cnt_d;
         timeout_q    <= timeout_d;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt       <= '0;
         flush_cnt_total <= '0;
      end else begin
         if (!pc_write_en && (stall_cnt != 16'hFFFF))      stall_cnt <= stall_cnt + 16'd1;
         if (if_id_flush && (flush_cnt_total != 16'hFFFF)) flush_cnt_total <= flush_cnt_total + 16'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
